// File: rtl/qam_symbol_demapper.sv
// QPSK/16QAM hard-decision demapper: slices I/Q samples to 2/4-bit words,
// queues them in a small FIFO and serializes them MSB-first over valid/ready.
module qam_symbol_demapper #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 536870912
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mod_type_i,
    input  logic               sym_valid_i,
    input  logic signed [31:0] sym_i_i,
    input  logic signed [31:0] sym_q_i,
    output logic               bit_out_o,
    output logic               bit_valid_o,
    input  logic               bit_ready_i,
    output logic               overflow_o,
    output logic [15:0]        sym_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic signed [31:0] THR_P = 32'(THRESH);
    localparam logic signed [31:0] THR_N = -THR_P;
    localparam logic [PW:0]        CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]        CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]      PTR_ONE  = PW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Comparing against both signed bounds avoids abs(), so -2^31 is safe.
    function automatic logic is_inner(input logic signed [31:0] x);
        return (x > THR_N) && (x < THR_P);
    endfunction

    logic [3:0]    word_s;
    logic          s1_v_q;
    logic [4:0]    s1_data_q;
    logic [4:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          full_s, empty_s, push_s, pop_s, drop_s, load_s, shift_s;
    logic [4:0]    fifo_out_s;
    state_t        state_q, state_d;
    logic [3:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          overflow_q;
    logic [15:0]   sym_count_q;

    always_comb begin
        word_s = 4'b0000;
        if (mod_type_i) begin
            word_s = {sym_i_i[31], is_inner(sym_i_i), sym_q_i[31], is_inner(sym_q_i)};
        end else begin
            word_s = {2'b00, sym_i_i[31], sym_q_i[31]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= 5'd0;
        end else begin
            s1_v_q <= sym_valid_i;
            if (sym_valid_i) begin
                s1_data_q <= {mod_type_i, word_s};
            end
        end
    end

    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == '0);
    assign push_s     = s1_v_q && (!full_s || pop_s);
    assign drop_s     = s1_v_q && full_s && !pop_s;
    assign fifo_out_s = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= 5'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            sym_count_q <= 16'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= s1_data_q;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
                sym_count_q     <= sym_count_q + 16'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Reload on the last handshake keeps the stream gap-free across words.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    load_s  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_ready_i) begin
                    if (bit_cnt_q == 3'd1) begin
                        if (!empty_s) begin
                            pop_s  = 1'b1;
                            load_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_s = 1'b1;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= 4'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            state_q <= state_d;
            if (load_s) begin
                if (fifo_out_s[4]) begin
                    shift_q   <= fifo_out_s[3:0];
                    bit_cnt_q <= 3'd4;
                end else begin
                    shift_q   <= {fifo_out_s[1:0], 2'b00};
                    bit_cnt_q <= 3'd2;
                end
            end else if (shift_s) begin
                shift_q   <= {shift_q[2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q - 3'd1;
            end
        end
    end

    assign bit_out_o   = shift_q[3];
    assign bit_valid_o = (state_q == SHIFT);
    assign overflow_o  = overflow_q;
    assign sym_count_o = sym_count_q;

endmodule

// File: tb/tb_qam_symbol_demapper.sv
// Self-checking bench for qam_symbol_demapper: directed scenarios plus a
// randomized stream scored against a bit-level reference queue.
module tb_qam_symbol_demapper;

    localparam int THRESH = 536870912;
    localparam int P28    = 268435456;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mod_type = 1'b0;
    logic               sym_valid = 1'b0;
    logic signed [31:0] sym_i = 32'sd0;
    logic signed [31:0] sym_q = 32'sd0;
    logic               bit_out, bit_valid, overflow;
    logic               bit_ready = 1'b0;
    logic [15:0]        sym_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic got_q[$];
    logic exp_q[$];

    qam_symbol_demapper #(.DEPTH(4), .THRESH(THRESH)) dut (
        .clk_i(clk), .rst_i(rst), .mod_type_i(mod_type), .sym_valid_i(sym_valid),
        .sym_i_i(sym_i), .sym_q_i(sym_q), .bit_out_o(bit_out), .bit_valid_o(bit_valid),
        .bit_ready_i(bit_ready), .overflow_o(overflow), .sym_count_o(sym_count)
    );

    always #5 clk = ~clk;

    // Record every accepted bit mid-cycle, away from the sampling edge.
    always @(negedge clk) begin
        if (!rst && bit_valid && bit_ready) got_q.push_back(bit_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sym_valid = 1'b0; tick(); tick();
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic send_sym(input logic m, input int i, input int q);
        mod_type = m; sym_i = i; sym_q = q; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
    endtask

    // Reference slicer: decisions taken straight from the sign/threshold rules.
    function automatic void model_push(input logic m, input int i, input int q);
        bit ni = (i < 0), nq = (q < 0);
        bit ii = (i > -THRESH) && (i < THRESH);
        bit iq = (q > -THRESH) && (q < THRESH);
        exp_q.push_back(ni);
        if (m) exp_q.push_back(ii);
        exp_q.push_back(nq);
        if (m) exp_q.push_back(iq);
    endfunction

    function automatic int stream_mismatches();
        int n = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            if (got_q[k] !== exp_q[k]) n++;
        return n;
    endfunction

    function automatic int rand_sample();
        case ($urandom_range(0, 7))
            0: return THRESH;
            1: return -THRESH;
            2: return THRESH - 1;
            3: return -THRESH + 1;
            4: return 32'sh8000_0000;
            5: return 0;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic wait_bits(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
        tests_run++; if (bit_out !== 1'b0) begin tests_failed++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tests_run++; if (sym_count !== 16'd0) begin tests_failed++; $display("FAIL reset_sym_count: got %0d want 0", sym_count); end
        rst = 1'b0;
    endtask

    task automatic test_qpsk_latency();
        do_reset();
        bit_ready = 1'b1;
        send_sym(1'b0, P28, -P28);
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c1: got %b want 0", bit_valid); end
        tick();
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c2: got %b want 0", bit_valid); end
        tick();
        tests_run++; if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin tests_failed++; $display("FAIL lat_c3: got v=%b d=%b want v=1 d=0", bit_valid, bit_out); end
        tick();
        tests_run++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin tests_failed++; $display("FAIL qpsk_bit1: got v=%b d=%b want v=1 d=1", bit_valid, bit_out); end
        tick();
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL qpsk_idle: got %b want 0", bit_valid); end
        tests_run++; if (sym_count !== 16'd1) begin tests_failed++; $display("FAIL qpsk_count: got %0d want 1", sym_count); end
    endtask

    task automatic test_16qam_sweep();
        int   vi[5] = '{3*P28, -P28, 32'sh8000_0000, THRESH, -THRESH};
        int   vq[5] = '{-P28, 3*P28, 0, -THRESH, THRESH};
        logic [3:0] vw[5] = '{4'b0011, 4'b1100, 4'b1001, 4'b0010, 4'b1000};
        logic [3:0] w;
        bit_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            got_q.delete();
            send_sym(1'b1, vi[t], vq[t]);
            wait_bits(4, 20);
            tick(); tick();
            w = 4'hx;
            if (got_q.size() == 4) w = {got_q[0], got_q[1], got_q[2], got_q[3]};
            tests_run++; if (w !== vw[t]) begin tests_failed++; $display("FAIL qam_word_%0d: got %b want %b (%0d bits)", t, w, vw[t], got_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_b[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        bit_ready = 1'b1;
        send_sym(1'b1, -3*P28, -3*P28);
        send_sym(1'b0, P28, -P28);
        for (int c = 0; c < 10 && !bit_valid; c++) tick();
        for (int k = 0; k < 6; k++) begin
            tests_run++; if (bit_valid !== 1'b1 || bit_out !== exp_b[k]) begin tests_failed++; $display("FAIL b2b_bit%0d: got v=%b d=%b want v=1 d=%b", k, bit_valid, bit_out, exp_b[k]); end
            tick();
        end
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got %b want 0", bit_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bit_ready = 1'b1;
        model_push(1'b1, 3*P28, -P28);
        send_sym(1'b1, 3*P28, -P28);
        for (int c = 0; c < 10 && !bit_valid; c++) tick();
        tick(); tick();
        bit_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++; if (bit_valid !== 1'b1 || bit_out !== exp_q[2]) begin tests_failed++; $display("FAIL bp_hold_%0d: got v=%b d=%b want v=1 d=%b", c, bit_valid, bit_out, exp_q[2]); end
        end
        bit_ready = 1'b1;
        wait_bits(4, 20);
        tick(); tick();
        tests_run++; if (stream_mismatches() !== 0) begin tests_failed++; $display("FAIL bp_stream: got %0d bits, %0d mismatches, want 4 bits 0", got_q.size(), stream_mismatches()); end
    endtask

    task automatic test_overflow();
        int i, q;
        do_reset();
        bit_ready = 1'b0;
        for (int s = 0; s < 7; s++) begin
            i = rand_sample(); q = rand_sample();
            if (s < 5) model_push(1'b1, i, q);
            send_sym(1'b1, i, q);
        end
        tick(); tick(); tick();
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        tests_run++; if (sym_count !== 16'd5) begin tests_failed++; $display("FAIL ovf_count: got %0d want 5", sym_count); end
        bit_ready = 1'b1;
        wait_bits(20, 60);
        tick(); tick();
        tests_run++; if (stream_mismatches() !== 0) begin tests_failed++; $display("FAIL ovf_stream: got %0d bits, %0d mismatches, want 20 bits 0", got_q.size(), stream_mismatches()); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_midstream();
        bit_ready = 1'b1;
        for (int s = 0; s < 4; s++) send_sym(1'b1, rand_sample(), rand_sample());
        rst = 1'b1;
        tick();
        tests_run++; if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b want 0", bit_valid); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
        tests_run++; if (sym_count !== 16'd0) begin tests_failed++; $display("FAIL mid_rst_count: got %0d want 0", sym_count); end
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 10; c++) tick();
        tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL mid_stale: got %0d bits want 0", got_q.size()); end
        model_push(1'b0, -P28, P28);
        send_sym(1'b0, -P28, P28);
        wait_bits(2, 20);
        tick(); tick();
        tests_run++; if (stream_mismatches() !== 0) begin tests_failed++; $display("FAIL mid_new: got %0d bits, %0d mismatches, want 2 bits 0", got_q.size(), stream_mismatches()); end
    endtask

    task automatic test_pop_on_full();
        int i, q;
        do_reset();
        bit_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            i = rand_sample(); q = rand_sample();
            model_push(1'b1, i, q);
            send_sym(1'b1, i, q);
        end
        tick(); tick(); tick();
        bit_ready = 1'b1;
        tick(); tick();
        i = rand_sample(); q = rand_sample();
        model_push(1'b1, i, q);
        send_sym(1'b1, i, q);
        tick();
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pof_overflow: got %b want 0", overflow); end
        wait_bits(24, 60);
        tick(); tick();
        tests_run++; if (sym_count !== 16'd6) begin tests_failed++; $display("FAIL pof_count: got %0d want 6", sym_count); end
        tests_run++; if (stream_mismatches() !== 0) begin tests_failed++; $display("FAIL pof_stream: got %0d bits, %0d mismatches, want 24 bits 0", got_q.size(), stream_mismatches()); end
    endtask

    task automatic test_random();
        logic m;
        int i, q;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            m = 1'($urandom_range(0, 1)); i = rand_sample(); q = rand_sample();
            model_push(m, i, q);
            send_sym(m, i, q);
            for (int g = 0; g < int'($urandom_range(10, 14)); g++) begin
                bit_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        bit_ready = 1'b1;
        wait_bits(exp_q.size(), 100);
        tick(); tick();
        tests_run++; if (stream_mismatches() !== 0) begin tests_failed++; $display("FAIL rand_stream: got %0d bits, %0d mismatches, want %0d bits 0", got_q.size(), stream_mismatches(), exp_q.size()); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rand_overflow: got %b want 0", overflow); end
        tests_run++; if (sym_count !== 16'd40) begin tests_failed++; $display("FAIL rand_count: got %0d want 40", sym_count); end
    endtask

    initial begin
        test_reset();
        test_qpsk_latency();
        test_16qam_sweep();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midstream();
        test_pop_on_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
